// File: rtl/ntt_pkg.sv
// Shared constants, types and modular helpers for the NTT matrix-vector datapath.
package ntt_pkg;

   localparam int          MAX_DW    = 64;
   localparam int          MAX_LANES = 16;
   localparam logic [63:0] DEFAULT_Q = 64'hFFFF_FFFF_0000_0001;

   typedef logic [MAX_DW-1:0]                  word_t;
   typedef logic [MAX_LANES-1:0][MAX_DW-1:0]   lane_vec_t;

   // Operands must already be below q; one conditional subtract suffices.
   function automatic word_t mod_add(input word_t a, input word_t b, input word_t q);
      logic [MAX_DW:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= {1'b0, q}) begin
         sum = sum - {1'b0, q};
      end
      return sum[MAX_DW-1:0];
   endfunction

endpackage

// File: rtl/ntt_modmul.sv
// One lane of modular multiply: full-width product register, then mod-Q reduction register.
module ntt_modmul
   import ntt_pkg::*;
#(
   parameter int            DW = 64,
   parameter logic [DW-1:0] Q  = DW'(DEFAULT_Q)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sclr,
   input  logic          en,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] w,
   output logic [DW-1:0] p
);

   logic [2*DW-1:0] prod_q, prod_d;
   logic [DW-1:0]   p_q, p_d;

   always_comb begin
      prod_d = prod_q;
      p_d    = p_q;
      if (sclr) begin
         prod_d = '0;
         p_d    = '0;
      end else if (en) begin
         prod_d = {{DW{1'b0}}, a} * {{DW{1'b0}}, w};
         p_d    = DW'(prod_q % {{DW{1'b0}}, Q});
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prod_q <= '0;
         p_q    <= '0;
      end else begin
         prod_q <= prod_d;
         p_q    <= p_d;
      end
   end

   assign p = p_q;

endmodule

// File: rtl/ntt_matvec_stream.sv
// Streaming y[r] = sum_c a[r][c]*w[r][c] mod Q, LANES elements per beat, one result per row.
module ntt_matvec_stream
   import ntt_pkg::*;
#(
   parameter int            DW    = 64,
   parameter logic [DW-1:0] Q     = DW'(DEFAULT_Q),
   parameter int            ROWS  = 64,
   parameter int            COLS  = 64,
   parameter int            LANES = 4,
   localparam int           RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sclr,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [LANES*DW-1:0] s_a,
   input  logic [LANES*DW-1:0] s_w,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [DW-1:0]       m_data,
   output logic [RW-1:0]       m_row,
   output logic                frame_done,
   output logic                busy
);

   localparam int BEATS = COLS / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int SW    = DW + $clog2(LANES) + 1;

   if (COLS % LANES != 0) begin : g_cols_chk
      $error("COLS must be a multiple of LANES");
   end
   if (LANES < 1 || LANES > MAX_LANES || (LANES & (LANES - 1)) != 0) begin : g_lanes_chk
      $error("LANES must be a power of two in 1..16");
   end
   if (DW > MAX_DW) begin : g_dw_chk
      $error("DW exceeds the package word width");
   end

   logic          stall, accept, hs;
   logic [BW-1:0] beat_q, beat_d;
   logic [RW-1:0] row_q, row_d;

   logic          vld_p0_q, vld_p0_d, first_p0_q, first_p0_d, last_p0_q, last_p0_d;
   logic [RW-1:0] row_p0_q, row_p0_d;
   logic          vld_p1_q, vld_p1_d, first_p1_q, first_p1_d, last_p1_q, last_p1_d;
   logic [RW-1:0] row_p1_q, row_p1_d;
   logic [DW-1:0] p_p1 [LANES];

   logic [SW-1:0] lane_sum_w;
   logic [DW-1:0] lane_sum, acc_base, acc_new;
   logic [DW-1:0] acc_q, acc_d, m_data_q, m_data_d;
   logic [RW-1:0] m_row_q, m_row_d;
   logic          m_valid_q, m_valid_d, frame_done_q, frame_done_d, busy_q, busy_d;

   assign stall   = m_valid_q && !m_ready;
   assign s_ready = !stall && !sclr;
   assign accept  = s_valid && s_ready;
   assign hs      = m_valid_q && m_ready;

   // Stage p0/p1: per-lane product register then reduced product, enabled unless stalled
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      ntt_modmul #(.DW(DW), .Q(Q)) u_modmul (
         .clk  (clk),
         .rst  (rst),
         .sclr (sclr),
         .en   (!stall),
         .a    (s_a[k*DW +: DW]),
         .w    (s_w[k*DW +: DW]),
         .p    (p_p1[k])
      );
   end

   // Stage 2: lane reduction and row accumulation
   always_comb begin
      lane_sum_w = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_sum_w = lane_sum_w + SW'(p_p1[k]);
      end
      lane_sum = DW'(lane_sum_w % SW'(Q));
      acc_base = first_p1_q ? '0 : acc_q;
      acc_new  = DW'(mod_add(MAX_DW'(acc_base), MAX_DW'(lane_sum), MAX_DW'(Q)));
   end

   always_comb begin
      beat_d       = beat_q;
      row_d        = row_q;
      vld_p0_d     = vld_p0_q;
      first_p0_d   = first_p0_q;
      last_p0_d    = last_p0_q;
      row_p0_d     = row_p0_q;
      vld_p1_d     = vld_p1_q;
      first_p1_d   = first_p1_q;
      last_p1_d    = last_p1_q;
      row_p1_d     = row_p1_q;
      acc_d        = acc_q;
      m_data_d     = m_data_q;
      m_row_d      = m_row_q;
      m_valid_d    = m_valid_q;
      frame_done_d = 1'b0;
      busy_d       = busy_q;
      if (sclr) begin
         beat_d     = '0;
         row_d      = '0;
         vld_p0_d   = 1'b0;
         first_p0_d = 1'b0;
         last_p0_d  = 1'b0;
         row_p0_d   = '0;
         vld_p1_d   = 1'b0;
         first_p1_d = 1'b0;
         last_p1_d  = 1'b0;
         row_p1_d   = '0;
         acc_d      = '0;
         m_data_d   = '0;
         m_row_d    = '0;
         m_valid_d  = 1'b0;
         busy_d     = 1'b0;
      end else begin
         if (accept) begin
            if (beat_q == BW'(BEATS - 1)) begin
               beat_d = '0;
               row_d  = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end
         if (!stall) begin
            vld_p0_d   = accept;
            first_p0_d = (beat_q == '0);
            last_p0_d  = (beat_q == BW'(BEATS - 1));
            row_p0_d   = row_q;
            vld_p1_d   = vld_p0_q;
            first_p1_d = first_p0_q;
            last_p1_d  = last_p0_q;
            row_p1_d   = row_p0_q;
            if (hs) begin
               m_valid_d = 1'b0;
            end
            if (vld_p1_q) begin
               acc_d = acc_new;
               if (last_p1_q) begin
                  m_data_d  = acc_new;
                  m_row_d   = row_p1_q;
                  m_valid_d = 1'b1;
               end
            end
         end
         frame_done_d = hs && (m_row_q == RW'(ROWS - 1));
         if (accept) begin
            busy_d = 1'b1;
         end else if (frame_done_d) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_q       <= '0;
         row_q        <= '0;
         vld_p0_q     <= 1'b0;
         first_p0_q   <= 1'b0;
         last_p0_q    <= 1'b0;
         row_p0_q     <= '0;
         vld_p1_q     <= 1'b0;
         first_p1_q   <= 1'b0;
         last_p1_q    <= 1'b0;
         row_p1_q     <= '0;
         acc_q        <= '0;
         m_data_q     <= '0;
         m_row_q      <= '0;
         m_valid_q    <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         beat_q       <= beat_d;
         row_q        <= row_d;
         vld_p0_q     <= vld_p0_d;
         first_p0_q   <= first_p0_d;
         last_p0_q    <= last_p0_d;
         row_p0_q     <= row_p0_d;
         vld_p1_q     <= vld_p1_d;
         first_p1_q   <= first_p1_d;
         last_p1_q    <= last_p1_d;
         row_p1_q     <= row_p1_d;
         acc_q        <= acc_d;
         m_data_q     <= m_data_d;
         m_row_q      <= m_row_d;
         m_valid_q    <= m_valid_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign m_row      = m_row_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule
